// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl: 8x8 unsigned multiply by issuing four nibble products to a shared 4x4 core and shift-accumulating them
module mult_8x8_seq_ctrl #(
  parameter logic [1:0] MODE_LL = 2'd0,
  parameter logic [1:0] MODE_LH = 2'd3,
  parameter logic [1:0] MODE_HL = 2'd3,
  parameter logic [1:0] MODE_HH = 2'd1,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        sub_valid,
  output logic [3:0]  sub_A,
  output logic [3:0]  sub_B,
  output logic [1:0]  sub_mode,
  input  logic [7:0]  sub_R,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state, k;
  logic [7:0] a_q, b_q;
  logic [15:0] acc, addend;
  logic cap_v;
  logic [1:0] cap_k;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign R = acc;
  assign sub_valid = state == ISSUE;
  assign sub_A = sub_valid ? (k[1] ? a_q[7:4] : a_q[3:0]) : 4'd0;
  assign sub_B = sub_valid ? (k[0] ? b_q[7:4] : b_q[3:0]) : 4'd0;
  // slot k selects the mode code; the core sees zero when no slot is issued
  always_comb
    sub_mode = !sub_valid ? 2'd0 : k == 2'd0 ? MODE_LL : k == 2'd1 ? MODE_LH : k == 2'd2 ? MODE_HL : MODE_HH;
  // weight of the captured partial product: LL x1, LH/HL x16, HH x256
  always_comb
    addend = {8'd0, sub_R} << (cap_k == 2'd0 ? 4'd0 : cap_k == 2'd3 ? 4'd8 : 4'd4);
  generate
    if (PIPE_LAT == 0) begin : g_comb
      assign cap_v = sub_valid;
      assign cap_k = k;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] tv;
      logic [1:0] tk [PIPE_LAT];
      // slot tags ride alongside the core latency so each result is weighted by the slot that produced it
      always_ff @(posedge clk) begin
        if (rst) begin
          tv <= '0;
          for (int i = 0; i < PIPE_LAT; i++) tk[i] <= 2'd0;
        end else begin
          tv[0] <= sub_valid;
          tk[0] <= k;
          for (int i = 1; i < PIPE_LAT; i++) begin
            tv[i] <= tv[i-1];
            tk[i] <= tk[i-1];
          end
        end
      end
      assign cap_v = tv[PIPE_LAT-1];
      assign cap_k = tk[PIPE_LAT-1];
    end
  endgenerate
  // sequencer: accept, issue four slots, wait for the last result, then hold the product until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= 2'd0;
      a_q <= 8'd0;
      b_q <= 8'd0;
      acc <= 16'd0;
    end else begin
      if (cap_v) acc <= acc + addend;
      case (state)
        IDLE: if (in_valid) begin
          a_q <= A;
          b_q <= B;
          acc <= 16'd0;
          k <= 2'd0;
          state <= (A == 8'd0 || B == 8'd0) ? DONE : ISSUE;
        end
        ISSUE: begin
          k <= k + 2'd1;
          if (k == 2'd3) state <= PIPE_LAT == 0 ? DONE : DRAIN;
        end
        DRAIN: if (cap_v && cap_k == 2'd3) state <= DONE;
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// tb_mult_8x8_seq_ctrl: three sequencer instances (latency 0/1/2) driven in lockstep against exact core models
module tb_mult_8x8_seq_ctrl;
  logic clk, rst, in_valid, out_ready;
  logic [7:0] a_in, b_in;
  logic ov [3], ir [3], sv [3], bz [3];
  logic [15:0] r [3];
  logic [3:0] sa [3], sb [3];
  logic [1:0] sm [3];
  logic [7:0] sr [3];
  logic [7:0] p1, p2a, p2b;
  int errs = 0, checks = 0;
  int lat_seen [3], n_sub [3], zviol [3];
  logic [15:0] r_seen [3];
  logic [10:0] seq [3][4];
  int lat [3] = '{0, 1, 2};
  logic [1:0] modes [3][4] = '{'{2'd0, 2'd0, 2'd0, 2'd0}, '{2'd0, 2'd3, 2'd3, 2'd1}, '{2'd0, 2'd3, 2'd3, 2'd1}};
  typedef struct {logic [7:0] a; logic [7:0] b; logic [15:0] r;} vec_t;
  vec_t v [9];
  initial clk = 0;
  always #5 clk = ~clk;
  assign sr[0] = {4'd0, sa[0]} * {4'd0, sb[0]};
  assign sr[1] = p1;
  assign sr[2] = p2b;
  always @(posedge clk) begin
    p1 <= {4'd0, sa[1]} * {4'd0, sb[1]};
    p2a <= {4'd0, sa[2]} * {4'd0, sb[2]};
    p2b <= p2a;
  end
  mult_8x8_seq_ctrl #(.MODE_LL(2'd0), .MODE_LH(2'd0), .MODE_HL(2'd0), .MODE_HH(2'd0), .PIPE_LAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .A(a_in), .B(b_in), .out_valid(ov[0]),
    .out_ready(out_ready), .R(r[0]), .sub_valid(sv[0]), .sub_A(sa[0]), .sub_B(sb[0]), .sub_mode(sm[0]),
    .sub_R(sr[0]), .busy(bz[0]));
  mult_8x8_seq_ctrl #(.PIPE_LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .A(a_in), .B(b_in), .out_valid(ov[1]),
    .out_ready(out_ready), .R(r[1]), .sub_valid(sv[1]), .sub_A(sa[1]), .sub_B(sb[1]), .sub_mode(sm[1]),
    .sub_R(sr[1]), .busy(bz[1]));
  mult_8x8_seq_ctrl #(.PIPE_LAT(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .A(a_in), .B(b_in), .out_valid(ov[2]),
    .out_ready(out_ready), .R(r[2]), .sub_valid(sv[2]), .sub_A(sa[2]), .sub_B(sb[2]), .sub_mode(sm[2]),
    .sub_R(sr[2]), .busy(bz[2]));
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s u%0d: got %0h expected %0h", name, i, act, exp);
    end
  endtask
  // called right after the accept edge; c counts edges since that edge
  task automatic collect();
    for (int i = 0; i < 3; i++) begin
      lat_seen[i] = -1;
      n_sub[i] = 0;
      r_seen[i] = 16'hxxxx;
      for (int s = 0; s < 4; s++) seq[i][s] = '0;
    end
    for (int c = 0; c < 12; c++) begin
      #1;
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && lat_seen[i] < 0) begin
          lat_seen[i] = c;
          r_seen[i] = r[i];
        end
        if (sv[i]) n_sub[i]++;
        if (c < 4) seq[i][c] = {sv[i], sa[i], sb[i], sm[i]};
        if (!sv[i] && {sa[i], sb[i], sm[i]} != 10'd0) zviol[i]++;
      end
      @(posedge clk);
    end
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    #1;
    a_in = a;
    b_in = b;
    in_valid = 1;
    @(posedge clk);
    collect();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{8'h0F, 8'h0F, 16'h00E1};
    v[1] = '{8'hFF, 8'hFF, 16'hFE01};
    v[2] = '{8'hA5, 8'h3C, 16'h26AC};
    v[3] = '{8'h12, 8'h34, 16'h03A8};
    v[4] = '{8'h00, 8'h55, 16'h0000};
    v[5] = '{8'h77, 8'h00, 16'h0000};
    v[6] = '{8'h80, 8'h80, 16'h4000};
    v[7] = '{8'hFF, 8'h01, 16'h00FF};
    v[8] = '{8'h01, 8'h01, 16'h0001};
    for (int i = 0; i < 3; i++) zviol[i] = 0;
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    a_in = 0;
    b_in = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", i, ov[i], 0);
      chk("rst_R", i, r[i], 0);
      chk("rst_sub", i, {sv[i], sa[i], sb[i], sm[i]}, 0);
      chk("rst_in_ready", i, ir[i], 1);
      chk("rst_busy", i, bz[i], 0);
    end
    rst = 0;
    for (int n = 0; n < 9; n++) begin
      logic zero;
      logic [7:0] a, b;
      a = v[n].a;
      b = v[n].b;
      zero = a == 8'd0 || b == 8'd0;
      run_op(a, b);
      for (int i = 0; i < 3; i++) begin
        chk("R", i, r_seen[i], v[n].r);
        chk("latency", i, lat_seen[i], zero ? 0 : 4 + lat[i]);
        chk("sub_count", i, n_sub[i], zero ? 0 : 4);
        if (!zero)
          for (int s = 0; s < 4; s++)
            chk("slot", i, seq[i][s], {1'b1, s[1] ? a[7:4] : a[3:0], s[0] ? b[7:4] : b[3:0], modes[i][s]});
      end
    end
    #1;
    out_ready = 0;
    a_in = 8'h12;
    b_in = 8'h34;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    begin
      int w;
      w = 0;
      while (!(ov[0] && ov[1] && ov[2]) && w < 12) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk("bp_reach_done", 0, w < 12, 1);
    end
    for (int h = 0; h < 3; h++) begin
      for (int i = 0; i < 3; i++) begin
        chk("bp_R", i, r[i], 16'h03A8);
        chk("bp_out_valid", i, ov[i], 1);
        chk("bp_in_ready", i, ir[i], 0);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    a_in = 8'h03;
    b_in = 8'h05;
    in_valid = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hs_out_valid", i, ov[i], 0);
      chk("hs_in_ready", i, ir[i], 1);
    end
    @(posedge clk);
    collect();
    for (int i = 0; i < 3; i++) begin
      chk("b2b_R", i, r_seen[i], 16'h000F);
      chk("b2b_latency", i, lat_seen[i], 4 + lat[i]);
    end
    #1;
    a_in = 8'hFF;
    b_in = 8'hFF;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_out_valid", i, ov[i], 0);
      chk("abort_sub_valid", i, sv[i], 0);
      chk("abort_in_ready", i, ir[i], 1);
    end
    run_op(8'h03, 8'h05);
    for (int i = 0; i < 3; i++) begin
      chk("after_abort_R", i, r_seen[i], 16'h000F);
      chk("after_abort_latency", i, lat_seen[i], 4 + lat[i]);
      chk("idle_sub_zero", i, zviol[i], 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
